// File: rtl/lfsr_mask_pkg.sv
// Shared types and helpers for the LFSR key masker: mode encoding, default
// polynomial/seed and the per-channel mask tap selection.
package lfsr_mask_pkg;

   typedef enum logic [1:0] {
      BYPASS   = 2'd0,
      STATIC   = 2'd1,
      PER_XFER = 2'd2,
      FREE_RUN = 2'd3
   } mode_e;

   localparam logic [19:0] DEF_TAPS = 20'h90000;   // x^20 + x^17 + 1
   localparam logic [19:0] DEF_SEED = 20'h3F364;
   localparam int          MAX_W    = 64;

   // Mask bit i of channel c is state bit (c*mask_w + i) mod lfsr_w, so wide
   // channel counts wrap around the state instead of running off the end.
   function automatic logic [MAX_W-1:0] chan_mask(input logic [MAX_W-1:0] s,
                                                  input int lfsr_w,
                                                  input int mask_w,
                                                  input int c);
      logic [MAX_W-1:0] m;
      logic [5:0]       idx;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         idx = 6'((c * mask_w + i) % lfsr_w);
         if (i < mask_w) m[i] = s[idx];
      end
      return m;
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with load and advance; an all-zero load value
// would lock the register up, so it is replaced by SEED and flagged.
module lfsr_galois #(
   parameter int                LFSR_W = 20,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(20'h90000),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(20'h3F364)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] state,
   output logic              zero_rej
);

   logic [LFSR_W-1:0] nxt;

   assign nxt      = (state >> 1) ^ (state[0] ? TAPS : '0);
   assign zero_rej = load && (load_val == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= SEED;
      else if (load)
         state <= zero_rej ? SEED : load_val;
      else if (adv)
         state <= nxt;
   end

endmodule

// File: rtl/lfsr_key_masker.sv
// Multi-channel key masking stage: XORs each key with a replicated LFSR-derived
// mask byte behind a single-entry valid/ready output register.
module lfsr_key_masker
   import lfsr_mask_pkg::*;
#(
   parameter int                LFSR_W = 20,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
   parameter int                KEY_W  = 128,
   parameter int                MASK_W = 8,
   parameter int                N_CH   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic                     seed_load,
   input  logic [LFSR_W-1:0]        seed_in,
   input  logic                     key_valid,
   output logic                     key_ready,
   input  logic [N_CH*KEY_W-1:0]    key_in,
   output logic                     masked_valid,
   input  logic                     masked_ready,
   output logic [N_CH*KEY_W-1:0]    masked_out,
   output logic [N_CH*MASK_W-1:0]   mask_out,
   output logic                     lock_err,
   output logic [15:0]              xfer_cnt
);

   logic [LFSR_W-1:0]               state;
   logic                            zero_rej;
   logic                            accept;
   logic                            adv;
   mode_e                           md;
   logic [N_CH-1:0][MASK_W-1:0]     mask;
   logic [N_CH-1:0][KEY_W-1:0]      masked_nxt;

   assign md        = mode_e'(mode);
   assign key_ready = !masked_valid || masked_ready;
   assign accept    = key_valid && key_ready;
   // Mask is taken from the pre-advance state, so advancing here is safe.
   assign adv       = (md == FREE_RUN) || ((md == PER_XFER) && accept);

   lfsr_galois #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (state),
      .zero_rej (zero_rej)
   );

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign mask[c] = (md == BYPASS) ? '0
                     : MASK_W'(chan_mask(MAX_W'(state), LFSR_W, MASK_W, c));
      assign masked_nxt[c] = key_in[c*KEY_W +: KEY_W] ^ {(KEY_W/MASK_W){mask[c]}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         masked_valid <= 1'b0;
         masked_out   <= '0;
         mask_out     <= '0;
         lock_err     <= 1'b0;
         xfer_cnt     <= '0;
      end else begin
         if (accept) begin
            masked_valid <= 1'b1;
            masked_out   <= masked_nxt;
            mask_out     <= mask;
            xfer_cnt     <= xfer_cnt + 16'd1;
         end else if (masked_ready) begin
            masked_valid <= 1'b0;
         end
         if (zero_rej) lock_err <= 1'b1;
      end
   end

endmodule
